// File: rtl/cpu_pc_sequencer_if.sv
// Next-PC control and PC/exception result bundle between the decode/execute path and the PC sequencer.
interface cpu_pc_sequencer_if;
  logic        stall;
  logic        branch_tk;
  logic [15:0] br_imm;
  logic        jump;
  logic [25:0] j_target;
  logic        jr;
  logic [31:0] jr_target;
  logic        irq;
  logic        illop;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] xadr;
  logic        xadr_we;
  logic        squash;
  logic        kernel;

  modport master (
    output stall, branch_tk, br_imm, jump, j_target, jr, jr_target, irq, illop,
    input  pc, pc_plus4, xadr, xadr_we, squash, kernel
  );

  modport slave (
    input  stall, branch_tk, br_imm, jump, j_target, jr, jr_target, irq, illop,
    output pc, pc_plus4, xadr, xadr_we, squash, kernel
  );
endinterface

// File: rtl/cpu_pc_sequencer.sv
// Program counter and next-PC selector for the single-cycle MIPS core, including
// interrupt/illegal-instruction entry, XADR generation and squash of the trapped instruction.
module cpu_pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
  input logic          clk,
  input logic          reset,
  cpu_pc_sequencer_if.slave bus
);

  logic [31:0] r_pc;
  logic        r_irq_q;
  logic        r_irq_pend;

  logic        w_kernel;
  logic [31:0] w_pc_plus4;
  logic [30:0] w_br_off;
  logic        w_irq_rise;
  logic        w_exc;
  logic        w_irq_take;
  logic [31:0] w_next_pc;
  logic [31:0] w_xadr;
  logic        w_xadr_we;
  logic        w_unused_jr;

  assign w_kernel    = r_pc[31];
  assign w_pc_plus4  = {r_pc[31], r_pc[30:0] + 31'd4};
  assign w_br_off    = {{13{bus.br_imm[15]}}, bus.br_imm, 2'b00};
  assign w_irq_rise  = bus.irq & ~r_irq_q;
  assign w_unused_jr = ^bus.jr_target[1:0];

  // Exception outranks interrupt; neither fires in kernel mode, during stall or reset.
  assign w_exc      = ~reset & ~bus.stall & bus.illop & ~w_kernel;
  assign w_irq_take = ~reset & ~bus.stall & ~w_exc & (r_irq_pend | w_irq_rise) & ~w_kernel;

  always_comb begin
    w_next_pc = w_pc_plus4;
    w_xadr    = w_pc_plus4;
    w_xadr_we = 1'b0;
    if (reset) begin
      w_next_pc = RESET_VEC;
    end else if (bus.stall) begin
      w_next_pc = r_pc;
    end else if (w_exc) begin
      w_next_pc = EXC_VEC;
      w_xadr_we = 1'b1;
    end else if (w_irq_take) begin
      // Return to the interrupted instruction itself so it re-executes.
      w_next_pc = IRQ_VEC;
      w_xadr    = r_pc;
      w_xadr_we = 1'b1;
    end else if (bus.jr) begin
      w_next_pc = {r_pc[31] & bus.jr_target[31], bus.jr_target[30:2], 2'b00};
    end else if (bus.jump) begin
      w_next_pc = {r_pc[31], w_pc_plus4[30:28], bus.j_target, 2'b00};
    end else if (bus.branch_tk) begin
      w_next_pc = {r_pc[31], w_pc_plus4[30:0] + w_br_off};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_VEC;
      r_irq_q    <= 1'b0;
      r_irq_pend <= 1'b0;
    end else begin
      r_pc       <= w_next_pc;
      r_irq_q    <= bus.irq;
      // A rise that is not taken right away (kernel, stall, or lost to an exception) is remembered.
      r_irq_pend <= (r_irq_pend | w_irq_rise) & ~w_irq_take;
    end
  end

  assign bus.pc       = r_pc;
  assign bus.pc_plus4 = w_pc_plus4;
  assign bus.xadr     = w_xadr;
  assign bus.xadr_we  = w_xadr_we;
  assign bus.squash   = w_xadr_we;
  assign bus.kernel   = w_kernel;

endmodule
